pwm_compare_stage: RTL and testbench



---
 rtl/pwm_compare_stage.sv | 85 ++++++++
 tb/tb_pwm_compare_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare_stage.sv
// PWM compare stage: turns the upstream modulus count into a registered PWM waveform,
// with duty updates staged through a one-entry pending slot and applied only at period boundaries.
module pwm_compare_stage #(
  parameter int LIMIT    = 12,
  parameter int CW       = 4,
  parameter int DUTY_RST = 0,
  parameter int POLARITY = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic [CW-1:0] cnt_in,
  input  logic [CW:0]   duty_in,
  input  logic          duty_valid,
  output logic          duty_ready,
  output logic [CW:0]   duty_active,
  output logic          pwm_out,
  output logic          period_start,
  output logic          update_done
);

  localparam logic [CW:0] LIMIT_W = (CW+1)'(LIMIT);
  localparam logic [CW:0] FULL_W  = (CW+1)'(LIMIT + 1);
  localparam logic [CW:0] RST_W   = (CW+1)'(DUTY_RST);
  localparam logic        POL     = (POLARITY != 0);

  // Requests beyond a full period saturate to "always active".
  function automatic logic [CW:0] clamp_duty(input logic [CW:0] d);
    return (d > FULL_W) ? FULL_W : d;
  endfunction

  logic [CW:0] cnt_ext;
  logic        boundary;
  logic        accept;
  logic        promote;

  logic [CW:0] pend_p0;
  logic        pend_full_p0;
  logic [CW:0] duty_act_p0;
  logic        pwm_p1;
  logic        period_start_p1;
  logic        update_done_p1;

  assign cnt_ext  = {1'b0, cnt_in};
  assign boundary = en && (cnt_ext == LIMIT_W);
  assign accept   = duty_valid && !pend_full_p0;
  assign promote  = boundary && pend_full_p0;

  // Stage p0: pending slot and active duty. Promotion and accept are mutually
  // exclusive because accept needs an empty slot and promotion needs a full one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_p0      <= '0;
      pend_full_p0 <= 1'b0;
      duty_act_p0  <= RST_W;
    end else if (promote) begin
      duty_act_p0  <= pend_p0;
      pend_full_p0 <= 1'b0;
    end else if (accept) begin
      pend_p0      <= clamp_duty(duty_in);
      pend_full_p0 <= 1'b1;
    end
  end

  // Stage p1: registered waveform and boundary pulses. The compare uses the duty in
  // effect before this edge, so a promoted duty first applies to the count-0 compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_p1          <= POL;
      period_start_p1 <= 1'b0;
      update_done_p1  <= 1'b0;
    end else begin
      pwm_p1          <= (en && (cnt_ext < duty_act_p0)) ^ POL;
      period_start_p1 <= boundary;
      update_done_p1  <= promote;
    end
  end

  assign duty_ready   = !pend_full_p0;
  assign duty_active  = duty_act_p0;
  assign pwm_out      = pwm_p1;
  assign period_start = period_start_p1;
  assign update_done  = update_done_p1;

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Scoreboard bench for pwm_compare_stage: two instances (active-high and inverted)
// share stimulus; a behavioural model pushes expected outputs, a monitor pops and compares.
module tb_pwm_compare_stage;
  localparam int LIMIT = 12;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic [CW-1:0] cnt_in = '0;
  logic [CW:0]   duty_in = '0;
  logic          duty_valid = 1'b0;

  logic          rdy0, rdy1, pwm0, pwm1, ps0, ps1, ud0, ud1;
  logic [CW:0]   act0, act1;

  pwm_compare_stage #(.LIMIT(LIMIT), .CW(CW), .DUTY_RST(0), .POLARITY(0)) u0 (
    .clk(clk), .reset_n(reset_n), .en(en), .cnt_in(cnt_in), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(rdy0), .duty_active(act0),
    .pwm_out(pwm0), .period_start(ps0), .update_done(ud0));

  pwm_compare_stage #(.LIMIT(LIMIT), .CW(CW), .DUTY_RST(3), .POLARITY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .en(en), .cnt_in(cnt_in), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(rdy1), .duty_active(act1),
    .pwm_out(pwm1), .period_start(ps1), .update_done(ud1));

  always #5 clk = ~clk;

  typedef struct {
    int pwm0, pwm1, ps, ud, rdy, act0, act1;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: duty in effect per instance and the pending slot.
  int   m_act[2];
  int   m_pend;
  int   m_pf;
  int   pol[2]     = '{0, 1};
  int   rst_duty[2] = '{0, 3};
  int   cnt_r = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, want);
    end
  endtask

  task automatic compare_all(input exp_t e);
    chk("pwm_out_pol0", int'(pwm0), e.pwm0);
    chk("pwm_out_pol1", int'(pwm1), e.pwm1);
    chk("period_start", int'(ps0), e.ps);
    chk("period_start_b", int'(ps1), e.ps);
    chk("update_done", int'(ud0), e.ud);
    chk("update_done_b", int'(ud1), e.ud);
    chk("duty_ready", int'(rdy0), e.rdy);
    chk("duty_ready_b", int'(rdy1), e.rdy);
    chk("duty_active_pol0", int'(act0), e.act0);
    chk("duty_active_pol1", int'(act1), e.act1);
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.pwm0 = pol[0]; e.pwm1 = pol[1]; e.ps = 0; e.ud = 0; e.rdy = 1;
    e.act0 = rst_duty[0]; e.act1 = rst_duty[1];
    return e;
  endfunction

  // Monitor: the stage presents a new output every clock; compare on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) compare_all(q.pop_front());
  end

  // One clock of stimulus; the model predicts what the outputs show after the next rising edge.
  task automatic step(input int e, input int v, input int d, input int c);
    exp_t x;
    int   bnd;
    @(negedge clk); #1;
    reset_n    = 1'b1;
    en         = 1'(e);
    duty_valid = 1'(v);
    duty_in    = (CW+1)'(d);
    cnt_in     = CW'(c);
    bnd = (e != 0) && (c == LIMIT);
    for (int i = 0; i < 2; i++) begin
      int hi;
      hi = ((e != 0) && (c < m_act[i])) ? 1 : 0;
      if (i == 0) x.pwm0 = hi ^ pol[i]; else x.pwm1 = hi ^ pol[i];
    end
    x.ps = bnd;
    x.ud = bnd && (m_pf != 0);
    if (bnd && m_pf != 0) begin
      m_act[0] = m_pend;
      m_act[1] = m_pend;
      m_pf = 0;
    end else if (v != 0 && m_pf == 0) begin
      m_pend = (d > LIMIT + 1) ? LIMIT + 1 : d;
      m_pf = 1;
    end
    x.rdy = (m_pf == 0);
    x.act0 = m_act[0];
    x.act1 = m_act[1];
    q.push_back(x);
  endtask

  task automatic tick(input int e, input int v, input int d);
    step(e, v, d, cnt_r);
    cnt_r = (cnt_r == LIMIT) ? 0 : cnt_r + 1;
  endtask

  task automatic run(input int n, input int e);
    for (int i = 0; i < n; i++) tick(e, 0, 0);
  endtask

  // Reset lands between edges; outputs must follow before any clock edge arrives.
  task automatic do_reset();
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    compare_all(reset_exp());
    m_act[0] = rst_duty[0];
    m_act[1] = rst_duty[1];
    m_pf = 0;
    m_pend = 0;
    q.push_back(reset_exp());
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, got %0d checks", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    m_act[0] = rst_duty[0];
    m_act[1] = rst_duty[1];
    m_pf = 0;
    m_pend = 0;

    do_reset();
    run(30, 1);

    tick(1, 1, 5);
    run(40, 1);

    tick(1, 1, 20);
    run(30, 1);
    tick(1, 1, 0);
    run(30, 1);

    waited = 0;
    while (cnt_r != LIMIT && waited < 20) begin
      tick(1, 0, 0);
      waited++;
    end
    chk("reach_boundary", cnt_r, LIMIT);
    tick(1, 1, 9);
    tick(1, 1, 11);
    run(30, 1);

    tick(1, 1, 7);
    run(20, 0);
    run(30, 1);

    tick(1, 1, 4);
    run(2, 1);
    do_reset();
    run(30, 1);

    for (int i = 0; i < 800; i++) begin
      int e, v, d, c;
      e = ($urandom_range(0, 9) < 8) ? 1 : 0;
      v = ($urandom_range(0, 9) < 2) ? 1 : 0;
      d = $urandom_range(0, 31);
      c = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : cnt_r;
      step(e, v, d, c);
      cnt_r = (cnt_r == LIMIT) ? 0 : cnt_r + 1;
      if (i == 400) do_reset();
    end

    repeat (3) @(negedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
